// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx -- 8N1 UART receiver that turns WASD keypresses into one-cycle
// one-hot move pulses for the grid-cursor block.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   rxd        raw serial line (idle high, LSB first, 8N1)
//   button     one-hot move pulse (d=0001, s=0010, w=0100, a=1000), 0 otherwise
//   rx_data    last correctly framed byte, held between frames
//   rx_valid   one-cycle pulse in the cycle rx_data is updated
//   frame_err  one-cycle pulse when a stop bit is sampled low
//
// Parameter:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [3:0] button,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      sh, sh_n;
    logic [7:0]      rx_data_n;
    logic            rx_valid_n, frame_err_n;
    logic [3:0]      button_n;
    logic            sync1, sync2;
    logic            rxs;

    // Two-flop synchronizer; resets to the idle (mark) level so reset never
    // looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end

    assign rxs = sync2;

    function automatic logic [3:0] decode(input logic [7:0] b);
        case (b)
            8'h64, 8'h44: decode = 4'b0001;   // d / D
            8'h73, 8'h53: decode = 4'b0010;   // s / S
            8'h77, 8'h57: decode = 4'b0100;   // w / W
            8'h61, 8'h41: decode = 4'b1000;   // a / A
            default:      decode = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            button    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
            button    <= button_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        sh_n        = sh;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        button_n    = 4'b0000;

        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            // Re-check the start bit half a bit later so short glitches are
            // dropped; from here on every sample lands mid-bit.
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = rxs ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n      = '0;
                    sh_n[idx]  = rxs;
                    idx_n      = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rxs) begin
                        state_n    = IDLE;
                        rx_data_n  = sh;
                        rx_valid_n = 1'b1;
                        button_n   = decode(sh);
                    end else begin
                        state_n     = BREAK;
                        frame_err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            // A low stop bit usually means a break or a baud mismatch; wait
            // for the line to return to mark before hunting for a start bit.
            BREAK: begin
                if (rxs) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

    localparam int CPB = 16;
    // raw line low -> rxs low after 2 clocks; stop sampled CPB/2 + 9*CPB
    // later; pulse visible one cycle after that.
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    typedef struct packed {
        int         cyc;
        logic       v;
        logic       fe;
        logic [7:0] data;
        logic [3:0] btn;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [3:0] button;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic [7:0] last_good = 8'h00;
    ev_t  evq[$];
    ev_t  expq[$];

    uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .button(button),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which any pulse output is active.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || frame_err || button != 4'b0000))
            evq.push_back('{cyc, rx_valid, frame_err, rx_data, button});
    end

    // Reference decode: position in the key table picks the one-hot bit.
    function automatic logic [3:0] ref_button(input logic [7:0] b);
        string keys;
        keys = "dDsSwWaA";
        ref_button = 4'b0000;
        for (int i = 0; i < 8; i++)
            if (b == keys[i]) ref_button = 4'b0001 << (i / 2);
    endfunction

    function automatic void expect_ok(input int t0, input logic [7:0] b);
        expq.push_back('{t0 + LAT, 1'b1, 1'b0, b, ref_button(b)});
        last_good = b;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stopb, output int t0);
        logic [9:0] f;
        f  = {stopb, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic clear_q();
        evq.delete();
        expq.delete();
    endtask

    task automatic test_reset();
        #1;
        compared++; if (button !== 4'b0000) begin mismatched++; $display("FAIL reset_button got %b want 0000", button); end
        compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_cmd_d();
        int t0;
        clear_q();
        send_frame(8'h64, 1'b1, t0);
        expect_ok(t0, 8'h64);
        repeat (10) @(negedge clk);
        compared++; if (evq.size() != expq.size()) begin mismatched++; $display("FAIL cmd_d count got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            compared++;
            if (evq[i] !== expq[i]) begin
                mismatched++;
                $display("FAIL cmd_d ev%0d got cyc=%0d v=%b fe=%b data=%h btn=%b want cyc=%0d v=%b fe=%b data=%h btn=%b", i,
                         evq[i].cyc, evq[i].v, evq[i].fe, evq[i].data, evq[i].btn, expq[i].cyc, expq[i].v, expq[i].fe, expq[i].data, expq[i].btn);
            end
        end
        compared++; if (rx_data !== 8'h64) begin mismatched++; $display("FAIL cmd_d_hold got %h want 64", rx_data); end
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        clear_q();
        send_frame(8'h41, 1'b1, t0);
        send_frame(8'h57, 1'b1, t1);
        expect_ok(t0, 8'h41);
        expect_ok(t1, 8'h57);
        repeat (10) @(negedge clk);
        compared++; if (evq.size() != expq.size()) begin mismatched++; $display("FAIL b2b count got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            compared++;
            if (evq[i] !== expq[i]) begin
                mismatched++;
                $display("FAIL b2b ev%0d got cyc=%0d v=%b fe=%b data=%h btn=%b want cyc=%0d v=%b fe=%b data=%h btn=%b", i,
                         evq[i].cyc, evq[i].v, evq[i].fe, evq[i].data, evq[i].btn, expq[i].cyc, expq[i].v, expq[i].fe, expq[i].data, expq[i].btn);
            end
        end
    endtask

    task automatic test_glitch_then_x();
        int t0;
        clear_q();
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(8'h78, 1'b1, t0);
        expect_ok(t0, 8'h78);
        repeat (10) @(negedge clk);
        compared++; if (evq.size() != expq.size()) begin mismatched++; $display("FAIL glitch_x count got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            compared++;
            if (evq[i] !== expq[i]) begin
                mismatched++;
                $display("FAIL glitch_x ev%0d got cyc=%0d v=%b fe=%b data=%h btn=%b want cyc=%0d v=%b fe=%b data=%h btn=%b", i,
                         evq[i].cyc, evq[i].v, evq[i].fe, evq[i].data, evq[i].btn, expq[i].cyc, expq[i].v, expq[i].fe, expq[i].data, expq[i].btn);
            end
        end
        compared++; if (rx_data !== 8'h78) begin mismatched++; $display("FAIL glitch_x_hold got %h want 78", rx_data); end
    endtask

    task automatic test_frame_err();
        int t0, t1;
        clear_q();
        send_frame(8'h73, 1'b0, t0);
        // bad frame: data unchanged, no button
        expq.push_back('{t0 + LAT, 1'b0, 1'b1, last_good, 4'b0000});
        repeat (40 - CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h73, 1'b1, t1);
        expect_ok(t1, 8'h73);
        repeat (10) @(negedge clk);
        compared++; if (evq.size() != expq.size()) begin mismatched++; $display("FAIL frame_err count got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            compared++;
            if (evq[i] !== expq[i]) begin
                mismatched++;
                $display("FAIL frame_err ev%0d got cyc=%0d v=%b fe=%b data=%h btn=%b want cyc=%0d v=%b fe=%b data=%h btn=%b", i,
                         evq[i].cyc, evq[i].v, evq[i].fe, evq[i].data, evq[i].btn, expq[i].cyc, expq[i].v, expq[i].fe, expq[i].data, expq[i].btn);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int t0, t1;
        clear_q();
        fork
            send_frame(8'h64, 1'b1, t0);
            begin
                repeat (5 * CPB + 8) @(negedge clk);   // middle of data bit 4
                #2 rst_n = 1'b0;
                #1;
                compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL midrst_rx_data got %h want 00", rx_data); end
                compared++; if (button !== 4'b0000 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
                    mismatched++; $display("FAIL midrst_pulses got btn=%b v=%b fe=%b want 0000/0/0", button, rx_valid, frame_err);
                end
            end
        join
        last_good = 8'h00;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (200) @(negedge clk);
        send_frame(8'h64, 1'b1, t1);
        expect_ok(t1, 8'h64);
        repeat (10) @(negedge clk);
        compared++; if (evq.size() != expq.size()) begin mismatched++; $display("FAIL midrst count got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            compared++;
            if (evq[i] !== expq[i]) begin
                mismatched++;
                $display("FAIL midrst ev%0d got cyc=%0d v=%b fe=%b data=%h btn=%b want cyc=%0d v=%b fe=%b data=%h btn=%b", i,
                         evq[i].cyc, evq[i].v, evq[i].fe, evq[i].data, evq[i].btn, expq[i].cyc, expq[i].v, expq[i].fe, expq[i].data, expq[i].btn);
            end
        end
    endtask

    task automatic test_random();
        int t0;
        logic [7:0] b;
        string keys;
        keys = "dDsSwWaA";
        clear_q();
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(1, 0) == 1) b = keys[$urandom_range(7, 0)];
            else                           b = 8'($urandom);
            send_frame(b, 1'b1, t0);
            expect_ok(t0, b);
            repeat ($urandom_range(3 * CPB, 0)) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        compared++; if (evq.size() != expq.size()) begin mismatched++; $display("FAIL random count got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            compared++;
            if (evq[i] !== expq[i]) begin
                mismatched++;
                $display("FAIL random ev%0d got cyc=%0d v=%b fe=%b data=%h btn=%b want cyc=%0d v=%b fe=%b data=%h btn=%b", i,
                         evq[i].cyc, evq[i].v, evq[i].fe, evq[i].data, evq[i].btn, expq[i].cyc, expq[i].v, expq[i].fe, expq[i].data, expq[i].btn);
            end
        end
        compared++; if (rx_data !== last_good) begin mismatched++; $display("FAIL random_hold got %h want %h", rx_data, last_good); end
    endtask

    initial begin
        test_reset();
        test_cmd_d();
        test_back_to_back();
        test_glitch_then_x();
        test_frame_err();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
